// File: rtl/tinycpu_isa_pkg.sv
// Shared ISA definitions for the tinycpu pipeline: micro-op classes, ALU ops,
// opcode field positions, handshake state encodings and the decoded bundle.
package tinycpu_isa_pkg;

  localparam int unsigned OP_W    = 8;
  localparam int unsigned CLASS_W = 3;
  localparam int unsigned ALU_W   = 2;
  localparam int unsigned REG_W   = 2;
  localparam int unsigned IMM_W   = 8;

  localparam logic [CLASS_W-1:0] UOP_ALU   = 3'd0;
  localparam logic [CLASS_W-1:0] UOP_LDI   = 3'd1;
  localparam logic [CLASS_W-1:0] UOP_LOAD  = 3'd2;
  localparam logic [CLASS_W-1:0] UOP_STORE = 3'd3;
  localparam logic [CLASS_W-1:0] UOP_JMP   = 3'd4;
  localparam logic [CLASS_W-1:0] UOP_BZ    = 3'd5;
  localparam logic [CLASS_W-1:0] UOP_NOP   = 3'd6;
  localparam logic [CLASS_W-1:0] UOP_HALT  = 3'd7;

  localparam logic [ALU_W-1:0] ALU_ADD = 2'd0;
  localparam logic [ALU_W-1:0] ALU_SUB = 2'd1;
  localparam logic [ALU_W-1:0] ALU_AND = 2'd2;
  localparam logic [ALU_W-1:0] ALU_OR  = 2'd3;

  // Opcode field bit positions
  localparam int unsigned OP_GRP_HI    = 7;
  localparam int unsigned OP_GRP_LO    = 6;
  localparam int unsigned OP_SUB_HI    = 5;
  localparam int unsigned OP_SUB_LO    = 4;
  localparam int unsigned OP_MID_HI    = 3;
  localparam int unsigned OP_MID_LO    = 2;
  localparam int unsigned OP_LOW_HI    = 1;
  localparam int unsigned OP_LOW_LO    = 0;
  localparam int unsigned OP_NIB_HI    = 3;
  localparam int unsigned OP_MEM_ST    = 5;
  localparam int unsigned OP_MEM_RD_HI = 4;
  localparam int unsigned OP_MEM_RD_LO = 3;
  localparam int unsigned OP_MEM_PAD_HI = 2;

  localparam logic [1:0] GRP_ALU = 2'b00;
  localparam logic [1:0] GRP_LDI = 2'b01;
  localparam logic [1:0] GRP_MEM = 2'b10;
  localparam logic [1:0] GRP_CTL = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DECODE    = 2'd1,
    WAIT_NEXT = 2'd2
  } hs_state_t;

  typedef struct packed {
    logic               illegal;
    logic [CLASS_W-1:0] uop_class;
    logic [ALU_W-1:0]   alu_op;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs;
    logic [IMM_W-1:0]   imm;
  } uop_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode-to-micro-op decoder; illegal encodings collapse to a
// NOP bundle with only the illegal flag set.
module opcode_decoder
  import tinycpu_isa_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output uop_t            uop
);

  logic [3:0] nib;
  logic       bad;
  uop_t       raw;

  assign nib = op[OP_NIB_HI:0];

  always_comb begin
    raw           = '0;
    raw.alu_op    = ALU_ADD;
    raw.uop_class = UOP_NOP;
    bad           = 1'b0;
    unique case (op[OP_GRP_HI:OP_GRP_LO])
      GRP_ALU: begin
        raw.uop_class = UOP_ALU;
        raw.alu_op    = op[OP_SUB_HI:OP_SUB_LO];
        raw.rd        = op[OP_MID_HI:OP_MID_LO];
        raw.rs        = op[OP_LOW_HI:OP_LOW_LO];
      end
      GRP_LDI: begin
        raw.uop_class = UOP_LDI;
        raw.rd        = op[OP_SUB_HI:OP_SUB_LO];
        raw.imm       = IMM_W'(nib);
      end
      GRP_MEM: begin
        raw.uop_class = op[OP_MEM_ST] ? UOP_STORE : UOP_LOAD;
        raw.rd        = op[OP_MEM_RD_HI:OP_MEM_RD_LO];
        bad           = (op[OP_MEM_PAD_HI:0] != 3'b000);
      end
      default: begin
        unique case (op[OP_SUB_HI:OP_SUB_LO])
          2'b00: begin
            raw.uop_class = UOP_JMP;
            raw.imm       = {{(IMM_W-4){nib[3]}}, nib};
          end
          2'b01: begin
            raw.uop_class = UOP_BZ;
            raw.imm       = {{(IMM_W-4){nib[3]}}, nib};
          end
          2'b10: begin
            raw.uop_class = UOP_NOP;
            bad           = (nib != 4'b0000);
          end
          default: begin
            raw.uop_class = UOP_HALT;
            bad           = (nib != 4'b0000);
          end
        endcase
      end
    endcase
  end

  // Illegal bundles carry no stale field data downstream
  always_comb begin
    uop = raw;
    if (bad) begin
      uop           = '0;
      uop.uop_class = UOP_NOP;
      uop.illegal   = 1'b1;
    end
  end

endmodule

// File: rtl/instruction_decode.sv
// Decode pipeline stage: DIR/ack_prev capture from fetch, registered micro-op
// bundle handed to execute over DOR/ack_from_next, with HALT latch and retire count.
module instruction_decode
  import tinycpu_isa_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned HALT_STOPS  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   DIR,
  output logic                   ack_prev,
  input  logic [OP_W-1:0]        data_in,
  output logic                   DOR,
  input  logic                   ack_from_next,
  output logic [CLASS_W-1:0]     uop_class,
  output logic [ALU_W-1:0]       alu_op,
  output logic [REG_W-1:0]       rd,
  output logic [REG_W-1:0]       rs,
  output logic [IMM_W-1:0]       imm,
  output logic                   illegal,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] insn_count
);

  hs_state_t       state;
  logic [OP_W-1:0] op_q;
  uop_t            dec;
  uop_t            bundle_q;
  logic            blocked;

  opcode_decoder u_opcode_decoder (
    .op  (op_q),
    .uop (dec)
  );

  assign blocked = (HALT_STOPS != 0) && halted;

  // Handshake FSM; DECODE never looks at DIR so a lingering DIR cannot re-capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= '0;
      bundle_q   <= '0;
      ack_prev   <= 1'b0;
      DOR        <= 1'b0;
      halted     <= 1'b0;
      insn_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (DIR && !blocked) begin
            op_q     <= data_in;
            ack_prev <= 1'b1;
            state    <= DECODE;
          end else begin
            ack_prev <= 1'b0;
            DOR      <= 1'b0;
          end
        end
        DECODE: begin
          ack_prev <= 1'b0;
          bundle_q <= dec;
          DOR      <= 1'b1;
          state    <= WAIT_NEXT;
        end
        WAIT_NEXT: begin
          if (ack_from_next) begin
            DOR        <= 1'b0;
            insn_count <= insn_count + COUNT_WIDTH'(1);
            if (bundle_q.uop_class == UOP_HALT && !bundle_q.illegal) begin
              halted <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: begin
          ack_prev <= 1'b0;
          DOR      <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign uop_class = bundle_q.uop_class;
  assign alu_op    = bundle_q.alu_op;
  assign rd        = bundle_q.rd;
  assign rs        = bundle_q.rs;
  assign imm       = bundle_q.imm;
  assign illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: scoreboarded decode bundles,
// handshake timing, HALT blocking, reset behaviour and counter wrap.
module tb_instruction_decode;

  logic       clk = 1'b0;
  logic       reset;
  logic       DIR;
  logic       ack_prev;
  logic [7:0] data_in;
  logic       DOR;
  logic       ack_from_next;
  logic [2:0] uop_class;
  logic [1:0] alu_op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [7:0] imm;
  logic       illegal;
  logic       halted;
  logic [7:0] insn_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [17:0] exp_q[$];
  logic [7:0]  exp_count;
  logic        exp_halted;
  logic [17:0] obs;

  always #5 clk = ~clk;

  assign obs = {illegal, uop_class, alu_op, rd, rs, imm};

  instruction_decode #(.COUNT_WIDTH(8), .HALT_STOPS(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .DIR           (DIR),
    .ack_prev      (ack_prev),
    .data_in       (data_in),
    .DOR           (DOR),
    .ack_from_next (ack_from_next),
    .uop_class     (uop_class),
    .alu_op        (alu_op),
    .rd            (rd),
    .rs            (rs),
    .imm           (imm),
    .illegal       (illegal),
    .halted        (halted),
    .insn_count    (insn_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference decode, packed as {illegal, class, alu_op, rd, rs, imm}
  function automatic logic [17:0] model(input logic [7:0] op);
    logic       ill;
    logic [2:0] cls;
    logic [1:0] a, d, s;
    logic [7:0] im;
    ill = 1'b0; cls = 3'd6; a = 2'd0; d = 2'd0; s = 2'd0; im = 8'd0;
    if (op < 8'h40) begin
      cls = 3'd0; a = op[5:4]; d = op[3:2]; s = op[1:0];
    end else if (op < 8'h80) begin
      cls = 3'd1; d = op[5:4]; im = op & 8'h0F;
    end else if (op < 8'hC0) begin
      cls = (op >= 8'hA0) ? 3'd3 : 3'd2;
      d = op[4:3];
      ill = ((op & 8'h07) != 8'h00);
    end else if (op < 8'hE0) begin
      cls = (op < 8'hD0) ? 3'd4 : 3'd5;
      im = op[3] ? ((op & 8'h0F) | 8'hF0) : (op & 8'h0F);
    end else begin
      cls = (op < 8'hF0) ? 3'd6 : 3'd7;
      ill = ((op & 8'h0F) != 8'h00);
    end
    if (ill) return {1'b1, 3'd6, 14'd0};
    return {1'b0, cls, a, d, s, im};
  endfunction

  task automatic run_insn(input logic [7:0] op, input int hold, input bit keep_dir, input bit do_ack);
    int          t;
    logic [17:0] exp;
    logic [17:0] snap;
    @(negedge clk);
    DIR = 1'b1;
    data_in = op;
    exp_q.push_back(model(op));
    t = 0;
    while (!ack_prev && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (!ack_prev) begin
      check("ack_timeout", 32'(ack_prev), 32'd1);
      DIR = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    if (!keep_dir) begin
      DIR = 1'b0;
      data_in = 8'($urandom);
    end
    @(negedge clk);
    check("ack_pulse", 32'(ack_prev), 32'd0);
    check("dor_rise", 32'(DOR), 32'd1);
    exp = exp_q.pop_front();
    check($sformatf("fields_%02h", op), 32'(obs), 32'(exp));
    snap = obs;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_dor", 32'(DOR), 32'd1);
      check("hold_fields", 32'(obs), 32'(snap));
      check("no_reack", 32'(ack_prev), 32'd0);
    end
    if (!do_ack) return;
    ack_from_next = 1'b1;
    DIR = 1'b0;
    if (exp[16:14] == 3'd7 && !exp[17]) exp_halted = 1'b1;
    exp_count++;
    @(negedge clk);
    ack_from_next = 1'b0;
    check("dor_fall", 32'(DOR), 32'd0);
    check("count", 32'(insn_count), 32'(exp_count));
    check("halted", 32'(halted), 32'(exp_halted));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit seen;
    reset = 1'b1; DIR = 1'b0; data_in = 8'h00; ack_from_next = 1'b0;
    exp_count = 8'd0; exp_halted = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dor", 32'(DOR), 32'd0);
    check("rst_ack", 32'(ack_prev), 32'd0);
    check("rst_fields", 32'(obs), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_count", 32'(insn_count), 32'd0);
    reset = 1'b0;

    run_insn(8'h1B, 0, 0, 1);
    check("sub_alu_op", 32'(alu_op), 32'd1);
    run_insn(8'h4F, 0, 0, 1);
    run_insn(8'hCE, 0, 0, 1);
    run_insn(8'hD8, 0, 0, 1);
    run_insn(8'h83, 0, 0, 1);
    run_insn(8'hE5, 0, 0, 1);
    run_insn(8'h90, 0, 0, 1);
    run_insn(8'hA8, 0, 0, 1);
    run_insn(8'hC5, 0, 0, 1);
    run_insn(8'hF1, 0, 0, 1);
    run_insn(8'h2D, 10, 1, 1);

    // Stray downstream ack while idle must not count
    @(negedge clk); ack_from_next = 1'b1;
    @(negedge clk); ack_from_next = 1'b0;
    check("stray_ack_count", 32'(insn_count), 32'(exp_count));
    check("stray_ack_dor", 32'(DOR), 32'd0);

    run_insn(8'hF0, 0, 0, 1);
    @(negedge clk); DIR = 1'b1; data_in = 8'h00;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ack_prev) seen = 1'b1;
    end
    check("halt_block_ack", 32'(seen), 32'd0);
    check("halt_block_dor", 32'(DOR), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; DIR = 1'b0;
    exp_count = 8'd0; exp_halted = 1'b0;
    check("unhalt", 32'(halted), 32'd0);
    check("unhalt_count", 32'(insn_count), 32'd0);
    run_insn(8'h00, 0, 0, 1);

    // Reset while the bundle waits downstream
    run_insn(8'h55, 2, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_count = 8'd0;
    check("midrst_dor", 32'(DOR), 32'd0);
    check("midrst_count", 32'(insn_count), 32'd0);
    check("midrst_ack", 32'(ack_prev), 32'd0);

    repeat (256) run_insn(8'hE0, 0, 0, 1);
    check("count_wrap", 32'(insn_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
